// File: rtl/fifo_rr_drain_arbiter_if.sv
// Handshake bundle between the arbiter, the per-channel show-ahead input FIFOs
// and the single shared output FIFO.
interface fifo_rr_drain_arbiter_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CH_W       = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]            in_empty;
  logic [NUM_CH*DATA_WIDTH-1:0] in_dout;
  logic [NUM_CH-1:0]            in_rd_en;
  logic                         out_full;
  logic                         out_wr_en;
  logic [DATA_WIDTH-1:0]        out_din;
  logic [CH_W-1:0]              out_ch;

  // Arbiter side.
  modport master (
    input  in_empty, in_dout, out_full,
    output in_rd_en, out_wr_en, out_din, out_ch
  );

  // FIFO side.
  modport slave (
    output in_empty, in_dout, out_full,
    input  in_rd_en, out_wr_en, out_din, out_ch
  );
endinterface

// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain of NUM_CH show-ahead input FIFOs into one output FIFO,
// granting each channel a burst of at most BURST_LEN words, tagged with its source.
module fifo_rr_drain_arbiter #(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int BURST_LEN  = 4,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_enable,
  fifo_rr_drain_arbiter_if.master  bus,
  output logic                     grant_valid,
  output logic [CH_W-1:0]          grant_ch,
  output logic [31:0]              xfer_count
);

  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic [CH_W-1:0]   grant_ch_d;
  logic              grant_valid_d;
  logic [31:0]       xfer_count_d;

  logic [NUM_CH-1:0] req;
  logic              pick_valid;
  logic [CH_W-1:0]   pick_ch;
  logic              xfer;
  logic              burst_last;
  int                idx;

  assign req        = ch_enable & ~bus.in_empty;
  assign burst_last = (burst_cnt_q == BW'(BURST_LEN - 1));

  // A word moves only while the granted channel is still enabled, has data and
  // the output has room; reset blocks it so an in-flight word is never popped.
  assign xfer = (state_q == XFER) && !reset && ch_enable[grant_ch] &&
                !bus.in_empty[grant_ch] && !bus.out_full;

  // Scan from rr_ptr downwards in distance so the nearest requester wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = '0;
    idx        = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_CH;
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_ch    = CH_W'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= IDLE;
      grant_valid <= 1'b0;
      grant_ch    <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      xfer_count  <= '0;
    end else begin
      state_q     <= state_d;
      grant_valid <= grant_valid_d;
      grant_ch    <= grant_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      xfer_count  <= xfer_count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a hold default first; a path that
    // leaves one unassigned would infer a latch.
    state_d       = state_q;
    grant_valid_d = grant_valid;
    grant_ch_d    = grant_ch;
    rr_ptr_d      = rr_ptr_q;
    burst_cnt_d   = burst_cnt_q;
    xfer_count_d  = xfer_count;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d       = XFER;
          grant_valid_d = 1'b1;
          grant_ch_d    = pick_ch;
          burst_cnt_d   = '0;
        end
      end
      XFER: begin
        if (xfer) begin
          burst_cnt_d  = burst_cnt_q + 1'b1;
          xfer_count_d = xfer_count + 32'd1;
        end
        // Empty or disable ends the grant even while stalled on out_full.
        if (!ch_enable[grant_ch] || bus.in_empty[grant_ch] || (xfer && burst_last)) begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
          rr_ptr_d      = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the transfer path is unregistered, straight from FIFO head.
  always_comb begin
    bus.in_rd_en           = '0;
    bus.in_rd_en[grant_ch] = xfer;
    bus.out_wr_en          = xfer;
    bus.out_din            = bus.in_dout[int'(grant_ch) * DATA_WIDTH +: DATA_WIDTH];
    bus.out_ch             = grant_ch;
  end

endmodule
